multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the RV32 core datapath per instruction: FETCH, DECODE, EXEC, MEM, WB.

---
 rtl/multicycle_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the RV32 core. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and returns to FETCH. The block
// drives the instruction/data memory handshakes and the per-state datapath
// strobes. It parks in HALT after an illegal opcode or a memory handshake
// timeout, and stays there until reset.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles a memory request may wait for ready (0 = off)
//   CNT_W          : wait counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   opcode          : instr[6:0] from the instruction register
//   branch_taken    : ALU branch-compare result (used in EXEC)
//   imem_req/ready  : instruction fetch handshake
//   dmem_req/we/rdy : data access handshake, dmem_we marks a store
//   ir_we, pc_we    : instruction register / PC load strobes
//   pc_src          : 0 = PC+4, 1 = branch target
//   alu_op          : 00 add, 01 branch compare, 10 R funct, 11 I funct
//   alu_src         : 0 = rs2, 1 = immediate
//   mem_to_reg      : writeback select, 1 = load data
//   reg_we          : register file write enable
//   instr_retired   : one-cycle pulse per completed instruction
//   illegal_op      : sticky illegal-opcode flag
//   bus_error       : sticky handshake timeout flag
//   state_dbg       : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_we,
    output logic       instr_retired,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic             bus_error_q;

    logic req_active;
    logic req_ready;
    logic timed_out;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_I) || (op == OP_BRANCH);
    endfunction

    // A single wait counter serves both handshakes; only one request can be
    // outstanding at a time.
    always_comb begin
        req_active = (state == FETCH) || (state == MEM);
        req_ready  = (state == FETCH) ? imem_ready : dmem_ready;
        timed_out  = TIMEOUT_EN && req_active && !req_ready &&
                     (wait_cnt == WAIT_LAST);
    end

    // wait_cnt is zeroed every cycle it is not counting, so it is already
    // clear on entry to FETCH or MEM from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= DECODE;
                    end else if (timed_out) begin
                        bus_error_q <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    op_q <= opcode;
                    if (is_legal(opcode)) begin
                        state <= EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state     <= HALT;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_R, OP_I:         state <= WB;
                        OP_LOAD, OP_STORE:  state <= MEM;
                        OP_BRANCH:          state <= FETCH;
                        default:            state <= HALT;
                    endcase
                end
                MEM: begin
                    if (dmem_ready) begin
                        state <= (op_q == OP_LOAD) ? WB : FETCH;
                    end else if (timed_out) begin
                        bus_error_q <= 1'b1;
                        state       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Outputs are decoded from the current state and ready inputs, and are
    // forced low while reset is asserted so an abandoned instruction cannot
    // leak a pc_we/reg_we or request.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 1'b0;
        alu_op        = 2'b00;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_we        = 1'b0;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;
        bus_error     = 1'b0;
        state_dbg     = 3'd0;
        if (!reset) begin
            state_dbg  = state;
            illegal_op = illegal_q;
            bus_error  = bus_error_q;
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                EXEC: begin
                    case (op_q)
                        OP_R: begin
                            alu_op = 2'b10;
                        end
                        OP_I: begin
                            alu_op  = 2'b11;
                            alu_src = 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_op  = 2'b00;
                            alu_src = 1'b1;
                        end
                        OP_BRANCH: begin
                            alu_op        = 2'b01;
                            pc_we         = 1'b1;
                            pc_src        = branch_taken;
                            instr_retired = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OP_STORE);
                    if (dmem_ready && (op_q == OP_STORE)) begin
                        pc_we         = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                WB: begin
                    reg_we        = 1'b1;
                    mem_to_reg    = (op_q == OP_LOAD);
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Expected per-cycle outputs are generated at instruction level: each
// instruction (with its chosen memory delays and branch outcome) expands into
// a list of cycles with the stimulus to apply and the outputs required. The
// list is then played against the DUT one clock at a time.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int TMO = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src;
  logic [1:0] alu_op;
  logic       alu_src, mem_to_reg, reg_we, instr_retired;
  logic       illegal_op, bus_error;
  logic [2:0] state_dbg;

  multicycle_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
    .instr_retired(instr_retired), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src;
    logic [1:0] alu_op;
    logic       alu_src, mem_to_reg, reg_we, retired, illegal, buserr;
  } outs_t;

  typedef struct {
    logic       rst, ir, dr, bt;
    logic [6:0] op;
    outs_t      exp;
  } step_t;

  step_t      steps[$];
  bit         m_ill = 1'b0;
  bit         m_bus = 1'b0;
  int         tests = 0;
  int         failed = 0;
  logic [6:0] legal_ops[5] = '{OP_R, OP_LOAD, OP_STORE, OP_I, OP_BRANCH};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_LOAD, OP_STORE, OP_I, OP_BRANCH};
  endfunction

  function automatic outs_t base(input logic [2:0] st);
    outs_t o = '0;
    o.st      = st;
    o.illegal = m_ill;
    o.buserr  = m_bus;
    return o;
  endfunction

  task automatic push(input logic rst, input logic ir, input logic dr,
                      input logic bt, input logic [6:0] op, input outs_t e);
    step_t s;
    s.rst = rst; s.ir = ir; s.dr = dr; s.bt = bt; s.op = op; s.exp = e;
    steps.push_back(s);
  endtask

  // Reset cycle with dmem_ready high: nothing may retire or strobe.
  task automatic gen_reset();
    m_ill = 1'b0;
    m_bus = 1'b0;
    push(1'b1, rb(), 1'b1, rb(), junk(), '0);
  endtask

  // HALT with imem_ready high: no fetch may be requested.
  task automatic gen_halt(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rb(), rb(), junk(), base(3'd5));
  endtask

  task automatic gen_instr(input logic [6:0] op, input int di, input int dd,
                           input logic bt, input bit abort_mem);
    outs_t o;
    bit    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    // FETCH
    o = base(3'd0);
    o.imem_req = 1'b1;
    if (di >= TMO) begin
      for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, rb(), rb(), junk(), o);
      m_bus = 1'b1;
      gen_halt(3);
      gen_reset();
      return;
    end
    for (int i = 0; i < di; i++) push(1'b0, 1'b0, rb(), rb(), junk(), o);
    o.ir_we = 1'b1;
    push(1'b0, 1'b1, rb(), rb(), junk(), o);
    // DECODE: opcode only presented here; EXEC must use the latched copy
    push(1'b0, rb(), rb(), rb(), op, base(3'd1));
    if (!legal(op)) begin
      m_ill = 1'b1;
      gen_halt(3);
      gen_reset();
      return;
    end
    // EXEC
    o = base(3'd2);
    case (op)
      OP_R:      o.alu_op = 2'b10;
      OP_I:      begin o.alu_op = 2'b11; o.alu_src = 1'b1; end
      OP_BRANCH: begin
        o.alu_op = 2'b01; o.pc_we = 1'b1; o.pc_src = bt; o.retired = 1'b1;
      end
      default:   begin o.alu_op = 2'b00; o.alu_src = 1'b1; end
    endcase
    push(1'b0, rb(), rb(), bt, junk(), o);
    if (op == OP_BRANCH) return;
    // MEM
    if (is_mem) begin
      o = base(3'd3);
      o.dmem_req = 1'b1;
      o.dmem_we  = (op == OP_STORE);
      if (abort_mem) begin
        push(1'b0, rb(), 1'b0, rb(), junk(), o);
        gen_reset();
        return;
      end
      if (dd >= TMO) begin
        for (int i = 0; i < TMO; i++) push(1'b0, rb(), 1'b0, rb(), junk(), o);
        m_bus = 1'b1;
        gen_halt(3);
        gen_reset();
        return;
      end
      for (int i = 0; i < dd; i++) push(1'b0, rb(), 1'b0, rb(), junk(), o);
      if (op == OP_STORE) begin
        o.pc_we = 1'b1;
        o.retired = 1'b1;
      end
      push(1'b0, rb(), 1'b1, rb(), junk(), o);
      if (op == OP_STORE) return;
    end
    // WB
    o = base(3'd4);
    o.reg_we     = 1'b1;
    o.mem_to_reg = (op == OP_LOAD);
    o.pc_we      = 1'b1;
    o.retired    = 1'b1;
    push(1'b0, rb(), rb(), rb(), junk(), o);
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 7) == 0) return 14 + int'($urandom_range(0, 3));
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    outs_t obs;
    logic [6:0] rop;
    bit prev_bus;

    prev_bus = 1'b0;
    gen_reset();
    gen_reset();
    // Directed cases
    gen_instr(OP_R,      0, 0, 1'b0, 1'b0);
    gen_instr(OP_R,      0, 0, 1'b0, 1'b0);
    gen_instr(OP_LOAD,   0, 3, 1'b0, 1'b0);
    gen_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
    gen_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0);
    gen_instr(OP_STORE,  0, 0, 1'b0, 1'b0);
    gen_instr(OP_I,      1, 0, 1'b0, 1'b0);
    gen_instr(7'b1111111, 0, 0, 1'b0, 1'b0);
    gen_instr(OP_R,      TMO - 1, 0, 1'b0, 1'b0);
    gen_instr(OP_R,      TMO, 0, 1'b0, 1'b0);
    gen_instr(OP_LOAD,   0, TMO - 1, 1'b0, 1'b0);
    gen_instr(OP_STORE,  0, TMO, 1'b0, 1'b0);
    gen_instr(OP_STORE,  0, 0, 1'b0, 1'b1);
    gen_instr(OP_LOAD,   2, 1, 1'b0, 1'b0);
    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) rop = junk();
      else rop = legal_ops[$urandom_range(0, 4)];
      gen_instr(rop, pick_delay(), pick_delay(), rb(),
                ($urandom_range(0, 14) == 0));
    end

    foreach (steps[k]) begin
      @(posedge clk);
      #1;
      reset        = steps[k].rst;
      imem_ready   = steps[k].ir;
      dmem_ready   = steps[k].dr;
      branch_taken = steps[k].bt;
      opcode       = steps[k].op;
      @(negedge clk);
      obs = {state_dbg, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
             alu_op, alu_src, mem_to_reg, reg_we, instr_retired,
             illegal_op, bus_error};

      if (steps[k].rst) begin
        tests++;
        assert (obs === '0) else begin
          failed++;
          $error("FAIL step%0d reset-state: observed=%h expected all zero",
                 k, obs);
        end
      end

      if (!steps[k].rst && steps[k].exp.buserr && !prev_bus) begin
        tests++;
        assert (bus_error === 1'b1 && state_dbg === 3'd5 &&
                imem_req === 1'b0 && dmem_req === 1'b0 &&
                pc_we === 1'b0 && reg_we === 1'b0 &&
                instr_retired === 1'b0) else begin
          failed++;
          $error("FAIL step%0d expired-wait: bus_error=%b state_dbg=%0d imem_req=%b dmem_req=%b",
                 k, bus_error, state_dbg, imem_req, dmem_req);
        end
      end
      prev_bus = steps[k].rst ? 1'b0 : steps[k].exp.buserr;

      tests++;
      assert (obs === steps[k].exp) else begin
        failed++;
        $error("FAIL step%0d outputs: observed=%h expected=%h",
               k, obs, steps[k].exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
